// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-interface target: FSM encodings,
// bus-level constants and small helpers.
`timescale 1ns/1ps
package i2c_pkg;

  localparam logic [3:0] BYTE_BITS = 4'd8;
  localparam logic       ACK_BIT   = 1'b0;
  localparam logic       NACK_BIT  = 1'b1;
  localparam logic       RW_READ   = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DEV_ADDR = 4'd1,
    ST_DEV_ACK  = 4'd2,
    ST_REG_ADDR = 4'd3,
    ST_REG_ACK  = 4'd4,
    ST_WR_DATA  = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD_LOAD  = 4'd7,
    ST_RD_DATA  = 4'd8,
    ST_RD_ACK   = 4'd9,
    ST_IGNORE   = 4'd10
  } i2c_state_e;

  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
    return (addr_byte[7:1] == dev);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Brings the raw SCL/SDA lines into the clk domain and derives SCL edges
// plus START/STOP conditions from the synchronized samples.
`timescale 1ns/1ps
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] form the synchronizer, [2] is the history flop used for edges.
  logic [2:0] r_scl;
  logic [2:0] r_sda;
  logic       w_scl_high;

  // Synchronizer and history chain; preset high to match an idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl <= 3'b111;
      r_sda <= 3'b111;
    end else begin
      r_scl <= {r_scl[1:0], scl_i};
      r_sda <= {r_sda[1:0], sda_i};
    end
  end

  assign w_scl_high = r_scl[1] & r_scl[2];
  assign sda_s      = r_sda[1];
  assign scl_rise   = r_scl[1] & ~r_scl[2];
  assign scl_fall   = ~r_scl[1] & r_scl[2];
  assign start_det  = w_scl_high & ~r_sda[1] & r_sda[2];
  assign stop_det   = w_scl_high & r_sda[1] & ~r_sda[2];

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target with an auto-incrementing 8-bit register pointer: written bytes
// become wr_en strobes, reads fetch through rd_en and shift out MSB first.
`timescale 1ns/1ps
module i2c_slave_regif #(
  parameter logic [6:0] DEV_ADDR = 7'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic [3:0] state_o
);
  import i2c_pkg::*;

  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start_det;
  logic       w_stop_det;
  logic       w_byte_done;

  i2c_state_e r_state;
  i2c_state_e w_state_nxt;
  logic [3:0] r_bit_cnt;
  logic [3:0] w_bit_cnt_nxt;
  logic [1:0] r_ld_cnt;
  logic [1:0] w_ld_cnt_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic [7:0] r_ptr;
  logic [7:0] w_ptr_nxt;
  logic       r_sda_oe;
  logic       w_sda_oe_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic       r_wr_en;
  logic       w_wr_en_nxt;
  logic [7:0] r_wr_addr;
  logic [7:0] w_wr_addr_nxt;
  logic [7:0] r_wr_data;
  logic [7:0] w_wr_data_nxt;
  logic       r_rd_en;
  logic       w_rd_en_nxt;
  logic [7:0] r_rd_addr;
  logic [7:0] w_rd_addr_nxt;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s     (w_sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start_det),
    .stop_det  (w_stop_det)
  );

  assign w_byte_done = (r_bit_cnt == BYTE_BITS);

  // State and datapath registers; reset also releases SDA asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 4'd0;
      r_ld_cnt  <= 2'd0;
      r_shift   <= 8'd0;
      r_ptr     <= 8'd0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 8'd0;
      r_wr_data <= 8'd0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_ld_cnt  <= w_ld_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_rd_addr <= w_rd_addr_nxt;
    end
  end

  // Next-state and output logic; START/STOP override any SCL edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_ld_cnt_nxt  = r_ld_cnt;
    w_shift_nxt   = r_shift;
    w_ptr_nxt     = r_ptr;
    w_sda_oe_nxt  = r_sda_oe;
    w_busy_nxt    = r_busy;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_rd_en_nxt   = 1'b0;
    w_rd_addr_nxt = r_rd_addr;

    if (w_stop_det) begin
      w_state_nxt   = ST_IDLE;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_bit_cnt_nxt = 4'd0;
    end else if (w_start_det) begin
      w_state_nxt   = ST_DEV_ADDR;
      w_sda_oe_nxt  = 1'b0;
      w_bit_cnt_nxt = 4'd0;
    end else begin
      case (r_state)
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (w_scl_rise && !w_byte_done) begin
            w_shift_nxt   = {r_shift[6:0], w_sda};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && w_byte_done) begin
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b1;
            if (r_state == ST_DEV_ADDR) begin
              if (addr_match(r_shift, DEV_ADDR)) begin
                w_state_nxt = ST_DEV_ACK;
                w_busy_nxt  = 1'b1;
              end else begin
                w_state_nxt  = ST_IGNORE;
                w_sda_oe_nxt = 1'b0;
              end
            end else if (r_state == ST_REG_ADDR) begin
              w_ptr_nxt   = r_shift;
              w_state_nxt = ST_REG_ACK;
            end else begin
              w_wr_en_nxt   = 1'b1;
              w_wr_addr_nxt = r_ptr;
              w_wr_data_nxt = r_shift;
              w_state_nxt   = ST_WR_ACK;
            end
          end else begin
            w_shift_nxt = r_shift;
          end
        end

        // Reads leave on the ACK rise so the first data bit is ready for the ACK fall.
        ST_DEV_ACK: begin
          if (w_scl_rise && (r_shift[0] == RW_READ)) begin
            w_state_nxt  = ST_RD_LOAD;
            w_ld_cnt_nxt = 2'd0;
          end else if (w_scl_fall) begin
            w_state_nxt   = ST_REG_ADDR;
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = 4'd0;
          end else begin
            w_state_nxt = ST_DEV_ACK;
          end
        end

        ST_REG_ACK, ST_WR_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt   = ST_WR_DATA;
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = 4'd0;
            if (r_state == ST_WR_ACK) begin
              w_ptr_nxt = r_ptr + 8'd1;
            end else begin
              w_ptr_nxt = r_ptr;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end

        // Request, wait one clk for the register side, then capture.
        ST_RD_LOAD: begin
          case (r_ld_cnt)
            2'd0: begin
              w_rd_en_nxt   = 1'b1;
              w_rd_addr_nxt = r_ptr;
              w_ld_cnt_nxt  = 2'd1;
            end
            2'd1: begin
              w_ld_cnt_nxt = 2'd2;
            end
            default: begin
              w_shift_nxt   = rd_data;
              w_bit_cnt_nxt = 4'd0;
              w_ld_cnt_nxt  = 2'd0;
              w_state_nxt   = ST_RD_DATA;
            end
          endcase
        end

        ST_RD_DATA: begin
          if (w_scl_fall) begin
            if (!w_byte_done) begin
              w_sda_oe_nxt  = ~r_shift[7];
              w_shift_nxt   = {r_shift[6:0], 1'b0};
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end else begin
              w_sda_oe_nxt  = 1'b0;
              w_bit_cnt_nxt = 4'd0;
              w_state_nxt   = ST_RD_ACK;
            end
          end else begin
            w_state_nxt = ST_RD_DATA;
          end
        end

        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda == ACK_BIT) begin
              w_ptr_nxt    = r_ptr + 8'd1;
              w_ld_cnt_nxt = 2'd0;
              w_state_nxt  = ST_RD_LOAD;
            end else begin
              w_state_nxt = ST_IGNORE;
            end
          end else begin
            w_state_nxt = ST_RD_ACK;
          end
        end

        ST_IDLE, ST_IGNORE: begin
          w_sda_oe_nxt = 1'b0;
        end

        default: begin
          w_state_nxt  = ST_IDLE;
          w_sda_oe_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe  = r_sda_oe;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign busy    = r_busy;
  assign state_o = r_state;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench: a bit-level I2C master drives the target at 100 kHz while a
// transaction-level model predicts strobes, ACKs and read data.
`timescale 1ns/1ps
module tb_i2c_slave_regif;

  localparam int Q = 2500;

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_oe;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic [3:0] state_o;
  logic       sda_line;

  int         vectors;
  int         errors;
  logic       quiet;
  logic [7:0] m_ptr;
  logic [7:0] mem [256];
  logic [15:0] exp_wr [$];
  logic [15:0] wr_log [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  rd_log [$];
  logic [15:0] cmp_w;
  logic [7:0]  cmp_r;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regif #(.DEV_ADDR(7'h55)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_m),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .state_o (state_o)
  );

  initial begin
    clk = 1'b0;
    #10;
    forever #50 clk = ~clk;
  end

  // Register side: read data appears on the clk after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endfunction

  function automatic logic addr_hit(input logic [7:0] b);
    return (b[7:1] == 7'h55);
  endfunction

  // Per-cycle compare against the model's expected strobe queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        wr_log.push_back({wr_addr, wr_data});
        if (exp_wr.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL wr_strobe: got unexpected wr_en addr=%h data=%h, required none", wr_addr, wr_data);
        end else begin
          cmp_w = exp_wr.pop_front();
          check("wr_strobe", 32'({wr_addr, wr_data}), 32'(cmp_w));
        end
      end
      if (rd_en) begin
        rd_log.push_back(rd_addr);
        if (exp_rd.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL rd_strobe: got unexpected rd_en addr=%h, required none", rd_addr);
        end else begin
          cmp_r = exp_rd.pop_front();
          check("rd_strobe", 32'(rd_addr), 32'(cmp_r));
        end
      end
      if (quiet) check("sda_released", 32'(sda_oe), 32'(1'b0));
    end
  end

  task automatic bus_start();
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b1; #(Q);
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m = b;    #(Q);
    scl_m = 1'b1; #(Q);
    s = sda_line; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = (s == 1'b0);
  endtask

  task automatic recv_byte(input logic m_nack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      v[i] = s;
    end
    send_bit(m_nack, s);
  endtask

  task automatic write_txn(input logic [7:0] regb, input logic [7:0] d0, input logic [7:0] d1);
    logic       ack;
    logic [7:0] d [2];
    d[0] = d0;
    d[1] = d1;
    bus_start();
    check("wr_start_state", 32'(state_o), 32'(4'd1));
    send_byte(8'hAA, ack);
    check("wr_dev_ack", 32'(ack), 32'(addr_hit(8'hAA)));
    check("wr_busy", 32'(busy), 32'(addr_hit(8'hAA)));
    send_byte(regb, ack);
    check("wr_reg_ack", 32'(ack), 32'(1'b1));
    m_ptr = regb;
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back({m_ptr, d[i]});
      m_ptr = m_ptr + 8'd1;
      send_byte(d[i], ack);
      check("wr_data_ack", 32'(ack), 32'(1'b1));
    end
    bus_stop();
    #(Q);
    check("wr_busy_after_stop", 32'(busy), 32'(1'b0));
    check("wr_idle_after_stop", 32'(state_o), 32'(4'd0));
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] v;
    logic [7:0] b;
    vectors = 0;
    errors  = 0;
    quiet   = 1'b0;
    m_ptr   = 8'd0;
    rd_data = 8'd0;
    scl_m   = 1'b1;
    sda_m   = 1'b1;
    rst     = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'hCC] = 8'h99;

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'(4'd0));
    check("rst_sda_oe", 32'(sda_oe), 32'(1'b0));
    check("rst_wr_en", 32'(wr_en), 32'(1'b0));
    check("rst_rd_en", 32'(rd_en), 32'(1'b0));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_addr_data", 32'({wr_addr, wr_data, rd_addr}), 32'(24'd0));
    #(Q);
    rst = 1'b0;
    #(Q);

    // Plain write of two bytes starting at 0xCC.
    write_txn(8'hCC, 8'h33, 8'h66);
    check("wr_log0_lit", 32'(wr_log[0]), 32'(16'hCC33));
    check("wr_log1_lit", 32'(wr_log[1]), 32'(16'hCD66));

    // Pointer wraps from 0xFF to 0x00.
    write_txn(8'hFF, 8'h01, 8'h02);
    check("wrap_log2_lit", 32'(wr_log[2]), 32'(16'hFF01));
    check("wrap_log3_lit", 32'(wr_log[3]), 32'(16'h0002));

    // Combined read with repeated START, master NACK.
    bus_start();
    send_byte(8'hAA, ack);
    check("rd_dev_ack_w", 32'(ack), 32'(addr_hit(8'hAA)));
    send_byte(8'hCC, ack);
    check("rd_reg_ack", 32'(ack), 32'(1'b1));
    m_ptr = 8'hCC;
    bus_start();
    check("rd_rstart_state", 32'(state_o), 32'(4'd1));
    exp_rd.push_back(m_ptr);
    send_byte(8'hAB, ack);
    check("rd_dev_ack_r", 32'(ack), 32'(addr_hit(8'hAB)));
    recv_byte(1'b1, v);
    check("rd_byte_model", 32'(v), 32'(mem[m_ptr]));
    check("rd_byte_lit", 32'(v), 32'(8'h99));
    check("rd_addr_lit", 32'(rd_log[0]), 32'(8'hCC));
    #(Q);
    check("rd_nack_ignore", 32'(state_o), 32'(4'd10));
    quiet = 1'b1;
    bus_stop();
    #(Q);
    quiet = 1'b0;
    check("rd_idle_after_stop", 32'(state_o), 32'(4'd0));

    // Address mismatch: no ACK, no strobes, SDA never pulled.
    quiet = 1'b1;
    bus_start();
    send_byte(8'hA8, ack);
    check("mm_dev_ack", 32'(ack), 32'(addr_hit(8'hA8)));
    check("mm_state", 32'(state_o), 32'(4'd10));
    send_byte(8'h12, ack);
    check("mm_byte_ack", 32'(ack), 32'(1'b0));
    bus_stop();
    #(Q);
    quiet = 1'b0;
    check("mm_busy", 32'(busy), 32'(1'b0));

    // Reset while the target holds the address ACK.
    b = 8'hAA;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    check("ack_held", 32'(sda_oe), 32'(addr_hit(b)));
    rst = 1'b1;
    #1;
    check("rst_ack_sda_oe", 32'(sda_oe), 32'(1'b0));
    check("rst_ack_state", 32'(state_o), 32'(4'd0));
    check("rst_ack_busy", 32'(busy), 32'(1'b0));
    #(Q);
    rst = 1'b0;
    #(Q);

    // Reset during bit 4 of the address byte, then a full write.
    bus_start();
    for (int i = 7; i >= 5; i--) send_bit(b[i], s);
    sda_m = b[4]; #(Q);
    scl_m = 1'b1; #(Q);
    rst = 1'b1;
    #1;
    check("rst_mid_sda_oe", 32'(sda_oe), 32'(1'b0));
    check("rst_mid_state", 32'(state_o), 32'(4'd0));
    sda_m = 1'b1;
    #(Q);
    rst = 1'b0;
    #(Q);
    write_txn(8'h40, 8'h5A, 8'hA5);

    // Repeated START after 3 data bits: no write, new address ACKed.
    b = 8'hF0;
    bus_start();
    send_byte(8'hAA, ack);
    check("rs_dev_ack", 32'(ack), 32'(addr_hit(8'hAA)));
    send_byte(8'h20, ack);
    check("rs_reg_ack", 32'(ack), 32'(1'b1));
    for (int i = 7; i >= 5; i--) send_bit(b[i], s);
    bus_start();
    check("rs_state", 32'(state_o), 32'(4'd1));
    send_byte(8'hAA, ack);
    check("rs_new_ack", 32'(ack), 32'(addr_hit(8'hAA)));
    send_byte(8'h21, ack);
    check("rs_new_reg_ack", 32'(ack), 32'(1'b1));
    bus_stop();
    #(Q);

    check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    check("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
    check("wr_count", 32'(wr_log.size()), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
